// File: rtl/isqrt_pkg.sv
// Shared definitions for the integer square-root block: FSM encoding, Q-format and width constants.
package isqrt_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int          Q15     = 15;
    localparam logic [15:0] S16_MAX = 16'h7FFF;
    localparam int          RAD_W   = 48;

endpackage

// File: rtl/isqrt_step.sv
// One digit-by-digit square-root step: brings in two radicand bits and resolves one root bit.
module isqrt_step
    import isqrt_pkg::*;
#(
    parameter int ROOT_W = 24,
    parameter int REM_W  = ROOT_W + 2
) (
    input  logic [REM_W-1:0]  rem_in,
    input  logic [ROOT_W-1:0] root_in,
    input  logic [1:0]        bits_in,
    output logic [REM_W-1:0]  rem_out,
    output logic [ROOT_W-1:0] root_out
);

    logic [REM_W+1:0] rem_sh;
    logic [REM_W+1:0] trial;

    // NOTE: every output gets a default before the branch so no latch is inferred.
    always_comb begin
        rem_sh   = {rem_in, bits_in};
        trial    = (REM_W+2)'({root_in, 2'b01});
        rem_out  = rem_sh[REM_W-1:0];
        root_out = {root_in[ROOT_W-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_out  = REM_W'(rem_sh - trial);
            root_out = {root_in[ROOT_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/isqrt_module.sv
// Iterative integer square root of a Q-format power value; inverts the upstream squaring stage.
// Build option: define ISQRT_ROUND_EN to round the root to nearest instead of truncating.
module isqrt_module
    import isqrt_pkg::*;
#(
    parameter int Q    = Q15,
    parameter int ITER = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sat
);

    localparam int RW = 2 * ITER;
    localparam int CW = $clog2(ITER);
    localparam logic [ITER:0] SAT_LIMIT = (ITER+1)'(S16_MAX);

    state_t          state;
    logic [RW-1:0]   rad;
    logic [ITER-1:0] root;
    logic [ITER-1:0] root_nx;
    logic [ITER+1:0] rem;
    logic [ITER+1:0] rem_nx;
    logic [CW-1:0]   cnt;
    logic [ITER:0]   root_fin;

    isqrt_step #(.ROOT_W(ITER)) u_step (
        .rem_in   (rem),
        .root_in  (root),
        .bits_in  (rad[RW-1 -: 2]),
        .rem_out  (rem_nx),
        .root_out (root_nx)
    );

    // Final root as seen on the last CALC cycle; one extra bit so rounding cannot wrap.
    always_comb begin
        root_fin = {1'b0, root_nx};
`ifdef ISQRT_ROUND_EN
        if (rem_nx > (ITER+2)'(root_nx)) begin
            root_fin = root_fin + (ITER+1)'(1);
        end
`endif
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rad      <= '0;
            root     <= '0;
            rem      <= '0;
            cnt      <= '0;
            data_out <= '0;
            sat      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        root <= '0;
                        rem  <= '0;
                        cnt  <= '0;
                        rad  <= RW'({data_in, {Q{1'b0}}});
                        if (data_in[31]) begin
                            state    <= ST_DONE;
                            data_out <= '0;
                            sat      <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rad  <= rad << 2;
                    root <= root_nx;
                    rem  <= rem_nx;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state <= ST_DONE;
                        if (root_fin > SAT_LIMIT) begin
                            data_out <= S16_MAX;
                            sat      <= 1'b1;
                        end else begin
                            data_out <= root_fin[15:0];
                            sat      <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_module.sv
// Self-checking bench for isqrt_module: directed corner values, randomized samples against a
// real-arithmetic square-root model, backpressure and mid-computation reset.
module tb_isqrt_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        sat;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam int LAT_POS = 25;
    localparam int LAT_NEG = 1;

    always #5 clk = ~clk;

    isqrt_module #(.Q(15), .ITER(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat)
    );

    // Reference: floor (or nearest) of sqrt(data_in * 2^15), clipped to 0x7FFF.
    function automatic void ref_isqrt(input logic [31:0] din, output logic [15:0] dout,
                                      output logic s);
        longint n;
        longint r;
        if (din[31]) begin
            dout = 16'h0000;
            s    = 1'b1;
            return;
        end
        n = longint'(din) * 32768;
        r = longint'($floor($sqrt(real'(n))));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
`ifdef ISQRT_ROUND_EN
        if (n - r * r > r) r++;
`endif
        if (r > 32767) begin
            dout = 16'h7FFF;
            s    = 1'b1;
        end else begin
            dout = 16'(r);
            s    = 1'b0;
        end
    endfunction

    // Present a sample and return at the first negedge after the accepting edge.
    task automatic start_sample(input logic [31:0] din, output bit accepted);
        int n = 0;
        @(negedge clk);
        data_in  = din;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        accepted = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Cycles from the acceptance cycle to the first cycle with out_valid (bounded).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (data_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data_out: got %h expected 0000", data_out);
        end
        tests_run++;
        if (sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sat: got %b expected 0", sat);
        end
    endtask

    task automatic test_directed;
        logic [31:0] vin  [7];
        logic [15:0] vout [7];
        logic        vsat [7];
        int          vlat [7];
        bit          acc;
        int          lat;
        vin[0] = 32'd8192;      vout[0] = 16'd16384; vsat[0] = 1'b0; vlat[0] = LAT_POS;
        vin[1] = 32'd0;         vout[1] = 16'd0;     vsat[1] = 1'b0; vlat[1] = LAT_POS;
`ifdef ISQRT_ROUND_EN
        vin[2] = 32'd32766;     vout[2] = 16'd32767; vsat[2] = 1'b0; vlat[2] = LAT_POS;
`else
        vin[2] = 32'd32766;     vout[2] = 16'd32766; vsat[2] = 1'b0; vlat[2] = LAT_POS;
`endif
        vin[3] = 32'd65536;     vout[3] = 16'h7FFF;  vsat[3] = 1'b1; vlat[3] = LAT_POS;
        vin[4] = 32'hFFFFFFFF;  vout[4] = 16'd0;     vsat[4] = 1'b1; vlat[4] = LAT_NEG;
        vin[5] = 32'h7FFFFFFF;  vout[5] = 16'h7FFF;  vsat[5] = 1'b1; vlat[5] = LAT_POS;
        vin[6] = 32'd1;         vout[6] = 16'd181;   vsat[6] = 1'b0; vlat[6] = LAT_POS;
        for (int i = 0; i < 7; i++) begin
            start_sample(vin[i], acc);
            tests_run++;
            if (!acc) begin
                tests_failed++;
                $display("FAIL directed_accept[%0d]: in_ready never rose", i);
            end
            wait_valid(lat);
            tests_run++;
            if (lat !== vlat[i]) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d] in=%h: got %0d expected %0d",
                         i, vin[i], lat, vlat[i]);
            end
            tests_run++;
            if (data_out !== vout[i]) begin
                tests_failed++;
                $display("FAIL directed_data[%0d] in=%h: got %0d expected %0d",
                         i, vin[i], data_out, vout[i]);
            end
            tests_run++;
            if (sat !== vsat[i]) begin
                tests_failed++;
                $display("FAIL directed_sat[%0d] in=%h: got %b expected %b",
                         i, vin[i], sat, vsat[i]);
            end
            consume();
        end
    endtask

    task automatic test_random;
        logic [31:0] din;
        logic [15:0] exp_out;
        logic        exp_sat;
        bit          acc;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0:       din = $urandom;
                1:       din = $urandom_range(32767, 0);
                2:       din = $urandom_range(40000, 30000);
                default: din = $urandom_range(255, 0);
            endcase
            ref_isqrt(din, exp_out, exp_sat);
            start_sample(din, acc);
            wait_valid(lat);
            tests_run++;
            if (!acc || lat !== (din[31] ? LAT_NEG : LAT_POS)) begin
                tests_failed++;
                $display("FAIL random_latency in=%h: got %0d expected %0d (accepted=%0d)",
                         din, lat, din[31] ? LAT_NEG : LAT_POS, acc);
            end
            tests_run++;
            if (data_out !== exp_out || sat !== exp_sat) begin
                tests_failed++;
                $display("FAIL random_result in=%h: got %0d/%b expected %0d/%b",
                         din, data_out, sat, exp_out, exp_sat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure;
        bit          acc;
        int          lat;
        int          bad = 0;
        logic [15:0] held;
        start_sample(32'd8192, acc);
        wait_valid(lat);
        held = data_out;
        tests_run++;
        if (!out_valid || held !== 16'd16384) begin
            tests_failed++;
            $display("FAIL bp_first: got valid=%b data=%0d expected valid=1 data=16384",
                     out_valid, held);
        end
        data_in  = 32'd65536;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1 || sat !== 1'b0)
                bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_consume: got valid=%b ready=%b expected valid=0 ready=1",
                     out_valid, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_ignored_second: got %0d valid cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_calc;
        bit          acc;
        int          lat;
        int          bad = 0;
        logic [15:0] exp_out;
        logic        exp_sat;
        start_sample(32'd123456, acc);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: got ready=%b valid=%b expected ready=1 valid=0",
                     in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_output: got %0d valid cycles expected 0", bad);
        end
        ref_isqrt(32'd20000, exp_out, exp_sat);
        start_sample(32'd20000, acc);
        wait_valid(lat);
        tests_run++;
        if (lat !== LAT_POS) begin
            tests_failed++;
            $display("FAIL rst_after_latency: got %0d expected %0d", lat, LAT_POS);
        end
        tests_run++;
        if (data_out !== exp_out || sat !== exp_sat) begin
            tests_failed++;
            $display("FAIL rst_after_result: got %0d/%b expected %0d/%b",
                     data_out, sat, exp_out, exp_sat);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
